mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 69 ++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: FSM state encoding and default sizing shared by mem_responder and mem_array
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_WAIT_STATES = 2;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 storage, one synchronous write port (we/waddr/wdata), one combinational read port (raddr/rdata), no reset
module mem_array import mem_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder; req_* in, resp_* out after WAIT_STATES cycles, state_out for debug
module mem_responder import mem_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [1:0]  state_out
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [2:0] cnt;
  logic wr_q, err, fire, accept;
  logic [31:0] addr_q, wdata_q, rd;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    accept = state == IDLE && req_valid;
    fire = state == WAIT && cnt == 3'd0;
    state_n = accept ? WAIT : fire ? RESP : (state == RESP && resp_ready) ? IDLE : state;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    state_out = state;
    err = addr_q[1:0] != 2'd0 || addr_q[31:2] >= 30'(DEPTH);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= 3'(WAIT_STATES - 1);
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (fire) begin
        resp_error <= err;
        resp_rdata <= (err || wr_q) ? 32'd0 : rd;
      end
      if (state == RESP && resp_ready) begin
        resp_rdata <= '0;
        resp_error <= 1'b0;
      end
    end
  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clock(clock),
    .we(fire && wr_q && !err),
    .waddr(addr_q[AW+1:2]),
    .wdata(wdata_q),
    .raddr(addr_q[AW+1:2]),
    .rdata(rd)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench running directed and random traffic on WAIT_STATES 1, 2 and 7
module tb_mem_responder;
  import mem_pkg::*;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clock) cyc++;
  typedef struct {logic [31:0] rdata; logic err; bit known; int acc; int hold;} exp_t;
  task automatic chk(input string name, input int ws, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ws=%0d actual=%h expected=%h", name, ws, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int WS = g == 0 ? 1 : g == 1 ? 2 : 7;
    logic reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0] state_out;
    exp_t q[$];
    logic [31:0] model [64];
    bit known [64];
    int hs_cyc = -100;
    bit fin = 1'b0;
    mem_responder #(.DEPTH(64), .WAIT_STATES(WS)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .state_out(state_out)
    );
    initial begin
      exp_t e;
      int rv_cnt = 0, hold = 0;
      logic [31:0] d0 = '0;
      logic e0 = 1'b0;
      bit was_hs = 1'b0;
      resp_ready = 1'b0;
      forever begin
        @(negedge clock);
        if (reset) begin
          rv_cnt = 0;
          resp_ready = 1'b0;
          was_hs = 1'b0;
          continue;
        end
        if (was_hs) begin
          chk("valid_drop", WS, 32'(resp_valid), 32'd0);
          chk("idle_after_hs", WS, 32'(state_out), 32'(IDLE));
          was_hs = 1'b0;
        end
        if (!resp_valid) begin
          chk("rdata_idle_zero", WS, resp_rdata, 32'd0);
          chk("error_idle_zero", WS, 32'(resp_error), 32'd0);
          rv_cnt = 0;
          resp_ready = 1'b0;
        end else begin
          chk("req_ready_busy", WS, 32'(req_ready), 32'd0);
          if (rv_cnt == 0) begin
            d0 = resp_rdata;
            e0 = resp_error;
            if (q.size() == 0) begin
              checks++;
              failures++;
              hold = 0;
              $display("FAIL unexpected_resp ws=%0d actual=resp_valid expected=no_response", WS);
            end else begin
              e = q.pop_front();
              hold = e.hold;
              chk("latency", WS, 32'(cyc - e.acc), 32'(WS));
              chk("resp_error", WS, 32'(resp_error), 32'(e.err));
              if (e.known) chk("resp_rdata", WS, resp_rdata, e.rdata);
            end
          end else begin
            chk("rdata_stable", WS, resp_rdata, d0);
            chk("error_stable", WS, 32'(resp_error), 32'(e0));
          end
          rv_cnt++;
          resp_ready = rv_cnt > hold;
          if (resp_ready) begin
            hs_cyc = cyc + 1;
            was_hs = 1'b1;
          end
        end
      end
    end
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int hold, input bit abandon = 1'b0);
      exp_t e;
      int acc, t = 0;
      bit waited = 1'b0, err;
      logic [5:0] idx;
      @(negedge clock);
      req_valid = 1'b1;
      req_write = wr;
      req_addr = addr;
      req_wdata = data;
      while (!req_ready && t < 40) begin
        @(negedge clock);
        t++;
        waited = 1'b1;
      end
      if (!req_ready) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout ws=%0d actual=req_ready_low expected=accept_within_40", WS);
        req_valid = 1'b0;
        return;
      end
      acc = cyc + 1;
      if (waited) chk("accept_after_hs", WS, 32'(acc), 32'(hs_cyc + 1));
      err = addr[1:0] != 2'd0 || addr >= 32'd256;
      idx = addr[7:2];
      if (!abandon) begin
        e.err = err;
        e.acc = acc;
        e.hold = hold;
        e.known = err || wr || known[idx];
        e.rdata = (err || wr) ? 32'd0 : model[idx];
        q.push_back(e);
        if (wr && !err) begin
          model[idx] = data;
          known[idx] = 1'b1;
        end
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      chk("state_wait", WS, 32'(state_out), 32'(WAIT));
    endtask
    initial begin
      int t;
      logic [31:0] a;
      foreach (known[i]) known[i] = 1'b0;
      reset = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      repeat (2) @(negedge clock);
      chk("rst_req_ready", WS, 32'(req_ready), 32'd1);
      chk("rst_resp_valid", WS, 32'(resp_valid), 32'd0);
      chk("rst_state", WS, 32'(state_out), 32'(IDLE));
      chk("rst_rdata", WS, resp_rdata, 32'd0);
      chk("rst_error", WS, 32'(resp_error), 32'd0);
      reset = 1'b0;
      issue(1'b1, 32'h10, 32'hDEADBEEF, 0);
      issue(1'b0, 32'h10, 32'h0, 0);
      issue(1'b1, 32'h0, 32'h0BADF00D, 0);
      issue(1'b0, 32'h12, 32'h0, 0);
      issue(1'b1, 32'h100, 32'hCAFEF00D, 0);
      issue(1'b0, 32'h0, 32'h0, 0);
      issue(1'b0, 32'h10, 32'h0, 5);
      issue(1'b0, 32'h0, 32'h0, 0);
      issue(1'b1, 32'h20, 32'hA5A5A5A5, 1);
      issue(1'b1, 32'h20, 32'h12345678, 0, 1'b1);
      reset = 1'b1;
      #1 chk("rst_in_wait_state", WS, 32'(state_out), 32'(IDLE));
      chk("rst_in_wait_ready", WS, 32'(req_ready), 32'd1);
      @(negedge clock) reset = 1'b0;
      issue(1'b0, 32'h20, 32'h0, 0);
      for (int i = 0; i < 40; i++) begin
        t = $urandom_range(0, 7);
        a = t == 0 ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) :
            t == 1 ? 32'h100 + 32'($urandom_range(0, 999) * 4) :
            32'($urandom_range(0, 63) * 4);
        issue(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end
      t = 0;
      while ((q.size() != 0 || resp_valid) && t < 100) begin
        @(negedge clock);
        t++;
      end
      chk("drain_pending", WS, 32'(q.size()), 32'd0);
      fin = 1'b1;
    end
  end
  initial begin
    int t = 0;
    while (!(u[0].fin && u[1].fin && u[2].fin) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (!(u[0].fin && u[1].fin && u[2].fin)) begin
      checks++;
      failures++;
      $display("FAIL global_timeout actual=unfinished expected=all_instances_done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
